// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential fixed-point divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

    localparam int unsigned DEF_WIDTH = 10;
    localparam int unsigned DEF_FRAC  = 4;
    localparam int unsigned ITER      = DEF_WIDTH + DEF_FRAC;

    // Number of quotient bits produced for a given format.
    function automatic int unsigned iter_count(input int unsigned width,
                                               input int unsigned frac);
        return width + frac;
    endfunction

    // Two's-complement magnitude of the low w bits of v (w <= 32).
    function automatic logic [31:0] abs_val(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        if (v[w-1]) begin
            return (~v + 32'd1) & mask;
        end
        return v & mask;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int unsigned WIDTH = 10
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {2'b00, i_div};

    // Borrow out of the extended subtract means the trial went negative.
    assign o_qbit = ~w_diff[WIDTH+1];
    assign o_rem  = w_diff[WIDTH+1] ? w_shift[WIDTH:0] : w_diff[WIDTH:0];

endmodule

// File: rtl/param_seq_divider.sv
// Multi-cycle restoring fixed-point divider: q = (a << FRAC) / b, signed or unsigned,
// with saturation on overflow and a start/busy/valid handshake.
module param_seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned FRAC  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dvz,
    output logic             ovf
);

    localparam int unsigned ITER_N = iter_count(WIDTH, FRAC);
    localparam int unsigned CW     = $clog2(ITER_N + 1);

    localparam logic [ITER_N:0] LIM_U  = (ITER_N + 1)'({WIDTH{1'b1}});
    localparam logic [ITER_N:0] LIM_SP = (ITER_N + 1)'({(WIDTH - 1){1'b1}});
    localparam logic [ITER_N:0] LIM_SN = LIM_SP + 1'b1;

    div_state_t        r_state;
    logic [CW-1:0]     r_cnt;
    logic [ITER_N-1:0] r_dq;
    logic [WIDTH:0]    r_rem;
    logic [WIDTH-1:0]  r_div;
    logic              r_signed;
    logic              r_neg_q;
    logic              r_neg_r;

    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic [WIDTH:0]    w_rem_next;
    logic              w_qbit;
    logic [ITER_N:0]   w_qmag_ext;
    logic              w_neg_res;
    logic              w_ovf;
    logic [WIDTH-1:0]  w_q_fix;
    logic [WIDTH-1:0]  w_r_fix;

    assign w_a_mag = signed_op ? WIDTH'(abs_val(32'(a), WIDTH)) : a;
    assign w_b_mag = signed_op ? WIDTH'(abs_val(32'(b), WIDTH)) : b;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dq[ITER_N-1]),
        .i_div  (r_div),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    // r_dq holds the dividend bits still to be consumed on the left and the
    // quotient bits produced so far on the right; after ITER_N steps it is the quotient.
    always_comb begin
        w_qmag_ext = {1'b0, r_dq};
        w_neg_res  = r_neg_q && (r_dq != '0);
        w_ovf      = 1'b0;
        w_q_fix    = r_dq[WIDTH-1:0];
        if (!r_signed) begin
            w_ovf   = w_qmag_ext > LIM_U;
            w_q_fix = w_ovf ? {WIDTH{1'b1}} : r_dq[WIDTH-1:0];
        end else if (w_neg_res) begin
            w_ovf   = w_qmag_ext > LIM_SN;
            w_q_fix = w_ovf ? {1'b1, {(WIDTH - 1){1'b0}}} : -r_dq[WIDTH-1:0];
        end else begin
            w_ovf   = w_qmag_ext > LIM_SP;
            w_q_fix = w_ovf ? {1'b0, {(WIDTH - 1){1'b1}}} : r_dq[WIDTH-1:0];
        end
        w_r_fix = r_neg_r ? WIDTH'(-r_rem) : WIDTH'(r_rem);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dq     <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            q        <= '0;
            r        <= '0;
            dvz      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_dq     <= ITER_N'(w_a_mag) << FRAC;
                        r_rem    <= '0;
                        r_div    <= w_b_mag;
                        r_signed <= signed_op;
                        r_neg_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r  <= signed_op & a[WIDTH-1];
                        q        <= '0;
                        r        <= '0;
                        ovf      <= 1'b0;
                        if (b == '0) begin
                            dvz     <= 1'b1;
                            valid   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            dvz     <= 1'b0;
                            valid   <= 1'b0;
                            busy    <= 1'b1;
                            r_cnt   <= CW'(ITER_N);
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // The extra cycle at r_cnt == 0 sets the documented start-to-valid latency.
                    if (r_cnt != '0) begin
                        r_rem <= w_rem_next;
                        r_dq  <= {r_dq[ITER_N-2:0], w_qbit};
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    q       <= w_q_fix;
                    r       <= w_r_fix;
                    ovf     <= w_ovf;
                    dvz     <= 1'b0;
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_seq_divider.sv
// Directed bench for param_seq_divider (WIDTH=10, FRAC=4): vector table plus handshake corners.
module tb_param_seq_divider;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       signed_op;
    logic [9:0] a;
    logic [9:0] b;
    logic       busy;
    logic       valid;
    logic [9:0] q;
    logic [9:0] r;
    logic       dvz;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       sgn;
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] q;
        logic [9:0] r;
        logic       ovf;
        logic       dvz;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    param_seq_divider #(
        .WIDTH (10),
        .FRAC  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .valid     (valid),
        .q         (q),
        .r         (r),
        .dvz       (dvz),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one start and wait for valid; lat counts edges after the start edge.
    task automatic do_op(input logic sgn, input logic [9:0] aa, input logic [9:0] bb,
                         output int lat);
        @(negedge clock);
        signed_op = sgn;
        a         = aa;
        b         = bb;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, (bb != 0) ? 1 : 0);
        chk("valid_after_start", valid, (bb == 0) ? 1 : 0);
        lat = 0;
        while (!valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 15) chk("busy_last_run", busy, 1);
        end
    endtask

    initial begin
        int lat;
        vecs[0]  = '{1'b0, 10'd100,  10'd32,   10'd50,   10'd0,   1'b0, 1'b0};
        vecs[1]  = '{1'b0, 10'd7,    10'd3,    10'd37,   10'd1,   1'b0, 1'b0};
        vecs[2]  = '{1'b0, 10'd1023, 10'd1,    10'h3FF,  10'd0,   1'b1, 1'b0};
        vecs[3]  = '{1'b1, 10'h3F9,  10'd3,    10'h3DB,  10'h3FF, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 10'd55,   10'd0,    10'd0,    10'd0,   1'b0, 1'b1};
        vecs[5]  = '{1'b1, 10'd7,    10'h3FD,  10'h3DB,  10'd1,   1'b0, 1'b0};
        vecs[6]  = '{1'b1, 10'h3F9,  10'h3FD,  10'd37,   10'h3FF, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 10'd100,  10'd3,    10'h1FF,  10'd1,   1'b1, 1'b0};
        vecs[8]  = '{1'b1, 10'h39C,  10'd3,    10'h200,  10'h3FF, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 10'd0,    10'd5,    10'd0,    10'd0,   1'b0, 1'b0};
        vecs[10] = '{1'b0, 10'd1023, 10'd1023, 10'd16,   10'd0,   1'b0, 1'b0};
        vecs[11] = '{1'b0, 10'd1000, 10'd7,    10'h3FF,  10'd5,   1'b1, 1'b0};
        vecs[12] = '{1'b1, 10'h3E0,  10'd1,    10'h200,  10'd0,   1'b0, 1'b0};
        vecs[13] = '{1'b1, 10'd32,   10'd1,    10'h1FF,  10'd0,   1'b1, 1'b0};
        vecs[14] = '{1'b0, 10'd63,   10'd1,    10'h3F0,  10'd0,   1'b0, 1'b0};
        vecs[15] = '{1'b0, 10'd64,   10'd1,    10'h3FF,  10'd0,   1'b1, 1'b0};
        vecs[16] = '{1'b0, 10'd1023, 10'd1000, 10'd16,   10'h170, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 10'h200,  10'd0,    10'd0,    10'd0,   1'b0, 1'b1};
        vecs[18] = '{1'b1, 10'h200,  10'h3FF,  10'h1FF,  10'd0,   1'b1, 1'b0};

        reset     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_dvz", dvz, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].dvz ? 0 : 16);
            chk($sformatf("v%0d_q", i), q, vecs[i].q);
            chk($sformatf("v%0d_r", i), r, vecs[i].r);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
            chk($sformatf("v%0d_dvz", i), dvz, vecs[i].dvz);
            chk($sformatf("v%0d_busy_done", i), busy, 0);
        end

        // Results hold in DONE while start stays low.
        repeat (3) @(posedge clock);
        #1;
        chk("hold_valid", valid, 1);
        chk("hold_q", q, 10'h1FF);

        // start with new operands during RUN must be ignored.
        @(negedge clock);
        signed_op = 1'b0;
        a         = 10'd100;
        b         = 10'd32;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("ign_valid_drop", valid, 0);
        chk("ign_q_zero", q, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        a     = 10'd7;
        b     = 10'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat   = 0;
        while (!valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("ign_valid", valid, 1);
        chk("ign_q", q, 10'd50);
        chk("ign_r", r, 10'd0);

        // Reset in the 5th RUN cycle aborts asynchronously.
        @(negedge clock);
        a     = 10'd100;
        b     = 10'd32;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_q", q, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("abort_idle_valid", valid, 0);
        do_op(1'b0, 10'd7, 10'd3, lat);
        chk("post_abort_latency", lat, 16);
        chk("post_abort_q", q, 10'd37);
        chk("post_abort_r", r, 10'd1);
        chk("post_abort_ovf", ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_seq_divider.md
Name: param_seq_divider

Overview:
- Parametrised multi-cycle restoring divider with a start/busy/valid handshake. It succeeds the fixed 10-bit divider.
- Adds generic width, generic fractional bits, per-operation signed/unsigned mode and a remainder output.
- Overflow saturates the quotient. Outputs are driven to 0 when not valid; there are no tri-states.
- Sits beside the ALU as the shared division unit for fixed-point datapaths.

Parameters:
- WIDTH, 10: operand/result width in bits.
- FRAC, 4: fractional bits of the fixed-point format. Quotient = (a << FRAC) / b. Legal range 0..WIDTH-1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a division; sampled only in IDLE or DONE.
- signed_op  in  1  1 = two's-complement operands and results; 0 = unsigned. Sampled with start.
- a  in  WIDTH  dividend; sampled with start.
- b  in  WIDTH  divisor; sampled with start.
- busy  out  1  high while an operation is in RUN or FIX.
- valid  out  1  result outputs are meaningful.
- q  out  WIDTH  quotient; 0 when valid=0.
- r  out  WIDTH  remainder; sign follows the dividend in signed mode; 0 when valid=0.
- dvz  out  1  divide by zero; qualified by valid.
- ovf  out  1  quotient overflow, saturated; qualified by valid.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, valid, q, r, dvz, ovf and counter all 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE with start=1:
  - Latch operands. In signed mode, operands are converted to magnitudes and the result sign is latched.
  - valid drops the next cycle.
  - If b==0: go to DONE in the next cycle with dvz=1, q=0, r=0, ovf=0, valid=1, busy never asserted.
  - Otherwise: go to RUN and load counter = WIDTH+FRAC.
- RUN:
  - One quotient bit per cycle: shift the partial remainder left by one, bringing in the next bit of the dividend extended by FRAC zero bits.
  - Trial-subtract |b|; restore if negative.
  - Decrement the counter; go to FIX after WIDTH+FRAC cycles.
- FIX (1 cycle):
  - Apply signs.
  - Evaluate overflow on the full (WIDTH+FRAC)-bit quotient:
    - unsigned: overflow if quotient > 2^WIDTH-1; saturate q to all ones.
    - signed: overflow if the result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]; saturate q to the extreme of the result's sign.
  - On overflow set ovf=1. r is still the true remainder magnitude, with the dividend's sign applied.
  - Then go to DONE.
- DONE: valid=1 and results are held stable until the next start or reset.
- Latency: with start sampled at edge k, busy=1 from k+1 through k+WIDTH+FRAC+1, and valid=1 from edge k+WIDTH+FRAC+2. With the defaults, valid rises 16 edges after the start edge.
- start while busy is ignored; operands are not re-sampled.
- start in DONE restarts the unit and clears valid, dvz and ovf on the next edge.
- Reset asserted mid-operation aborts immediately; no partial result is ever presented.
- Signed edge case: a=-2^(WIDTH-1), b=-1 with FRAC=0 gives ovf=1 and q=2^(WIDTH-1)-1.
- Internal widths:
  - partial remainder: WIDTH+1 bits.
  - dividend shift register: WIDTH+FRAC bits.
  - counter: clog2(WIDTH+FRAC+1) bits.

Decomposition:
- Shared package div_pkg holds:
  - state enum div_state_t {IDLE, RUN, FIX, DONE};
  - an abs-value helper function;
  - a localparam computing ITER = WIDTH+FRAC.
- One combinational sub-module, div_step, is natural: a trial subtract/restore of the partial remainder against |b|, returning the next remainder and the quotient bit.
- Control FSM, counter and sign fix stay in param_seq_divider.

Test Plan (WIDTH=10, FRAC=4):
- Unsigned, a=100, b=32, start -> 16 edges later valid=1, q=50, r=0, ovf=0, dvz=0, busy low.
- Unsigned, a=7, b=3 -> q=37, r=1.
- Unsigned, a=1023, b=1 -> ovf=1, q=10'h3FF.
- Signed, a=10'h3F9 (-7), b=3 -> q=10'h3DB (-37), r=10'h3FF (-1), ovf=0.
- b=0, a=55 -> dvz=1, valid=1 on the first edge after start; busy stays 0; q=0, r=0.
- Control and reset behaviour:
  - start pulsed during RUN with new operands -> ignored; the original result is returned.
  - reset=0 in the 5th RUN cycle -> busy=0 and valid=0 immediately (asynchronous); the next start then runs cleanly.
